// File: rtl/mem_bus_master_pkg.sv
// mem_bus_pkg: shared constants for the memory bus master (FSM states, bus widths, m_rw_ encodings).
package mem_bus_pkg;
    localparam int MB_ADDR_W    = 12;
    localparam int MB_DATA_W    = 32;
    localparam int MB_MEM_DEPTH = 32;
    localparam logic M_READ  = 1'b1;
    localparam logic M_WRITE = 1'b0;
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_RD     = 3'd1;
    localparam state_t S_RD_CAP = 3'd2;
    localparam state_t S_WR     = 3'd3;
    localparam state_t S_RSP    = 3'd4;
endpackage

// File: rtl/mem_bus_master.sv
// mem_bus_master: single-outstanding initiator for the m_addr/m_data/m_rw_ bus; MEM_BUS_MASTER_RANGE_CHECK_EN enables out-of-range rejection.
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W    = MB_ADDR_W,
    parameter int DATA_W    = MB_DATA_W,
    parameter int MEM_DEPTH = MB_MEM_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] m_addr,
    inout  wire  [DATA_W-1:0] m_data,
    output logic              m_rw_,
    output logic              busy
);
`ifdef MEM_BUS_MASTER_RANGE_CHECK_EN
    localparam logic CHECK = 1'b1;
`else
    localparam logic CHECK = 1'b0;
`endif
    state_t state;
    logic [DATA_W-1:0] wdata_q;
    logic accept, oor;
    assign req_ready = (state == S_IDLE) && !rsp_valid;
    assign busy      = state != S_IDLE;
    assign accept    = req_valid && req_ready;
    assign oor       = CHECK && (req_addr >= ADDR_W'(MEM_DEPTH));
    // Driver keys off the state register, so reset releases the bus asynchronously.
    assign m_data    = (state == S_WR) ? wdata_q : {DATA_W{1'bz}};
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            rsp_we    <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            m_addr    <= '0;
            m_rw_     <= M_READ;
            wdata_q   <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    wdata_q <= req_wdata;
                    if (oor) begin
                        state     <= S_RSP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_we    <= req_we;
                        rsp_rdata <= '0;
                    end else begin
                        m_addr <= req_addr;
                        m_rw_  <= req_we ? M_WRITE : M_READ;
                        state  <= req_we ? S_WR : S_RD;
                    end
                end
                S_RD: state <= S_RD_CAP;
                S_RD_CAP: begin
                    rsp_rdata <= m_data;
                    rsp_valid <= 1'b1;
                    rsp_we    <= 1'b0;
                    rsp_err   <= 1'b0;
                    state     <= S_RSP;
                end
                S_WR: begin
                    m_rw_     <= M_READ;
                    rsp_valid <= 1'b1;
                    rsp_we    <= 1'b1;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                    state     <= S_RSP;
                end
                S_RSP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
`ifdef MEM_BUS_MASTER_RANGE_CHECK_EN
    logic [15:0] err_count;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) err_count <= '0;
        else if (accept && oor && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: table-driven scoreboard bench for mem_bus_master with a behavioural single-port memory.
module tb_mem_bus_master;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
    logic [11:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_we, rsp_err, m_rw_, busy;
    logic [31:0] rsp_rdata;
    logic [11:0] m_addr;
    wire  [31:0] m_data;

    mem_bus_master dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .m_addr(m_addr),
        .m_data(m_data), .m_rw_(m_rw_), .busy(busy)
    );

    always #5 clock = ~clock;

    // Memory: registers read data one edge after the address, drives it only in the capture window.
    logic [31:0] mem [32];
    logic [31:0] mem_q = '0;
    logic        drv = 1'b0;
    assign m_data = drv ? mem_q : 32'hzzzz_zzzz;
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'hA000_0000 | i;
            mem[0] <= 32'h2800_0001;
            mem[3] <= 32'h4800_1001;
            mem[9] <= 32'h5555_AAAA;
        end else if (!m_rw_ && m_addr < 12'd32) mem[m_addr[4:0]] <= m_data;
        mem_q <= (m_addr < 12'd32) ? mem[m_addr[4:0]] : 32'h0;
        drv   <= m_rw_ && busy && !rsp_valid;
    end

    int hs = 0;
    always @(posedge clock) if (!reset && rsp_valid && rsp_ready) hs <= hs + 1;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        int          hold;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } vec_t;
    typedef struct {
        logic        we;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    vec_t tbl[9];
    int n_tests = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v);
        exp_t e, g;
        int lat, lows, h0;
        logic got;
        logic [11:0] a0;
        e = '{we: v.we, rdata: v.rdata, err: v.err, lat: v.lat};
        a0 = v.err ? m_addr : v.addr;
        exp_q.push_back(e);
        rsp_ready = (v.hold == 0);
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        @(posedge clock); #1;
        req_valid = 1'b0;
        lows = m_rw_ ? 0 : 1;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clock); #1;
            lat++;
            got = rsp_valid;
            lows += m_rw_ ? 0 : 1;
        end
        g = exp_q.pop_front();
        if (!got) begin
            chk("rsp_timeout", 32'd0, 32'd1);
            return;
        end
        h0 = hs;
        chk("rsp_latency", lat, g.lat);
        chk("rsp_we", {31'b0, rsp_we}, {31'b0, g.we});
        chk("rsp_rdata", rsp_rdata, g.rdata);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, g.err});
        chk("m_rw_low_cycles", lows, (g.we && !g.err) ? 32'd1 : 32'd0);
        chk("m_addr", {20'b0, m_addr}, {20'b0, a0});
        for (int i = 0; i < v.hold; i++) begin
            chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
            chk("hold_rdata", rsp_rdata, g.rdata);
            chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
            @(posedge clock); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        chk("rsp_cleared", {31'b0, rsp_valid}, 32'd0);
        chk("req_ready_after", {31'b0, req_ready}, 32'd1);
        chk("handshakes", hs - h0, 32'd1);
    endtask

    initial begin
        tbl[0] = '{1'b0, 12'd0,  32'h0,         0, 32'h2800_0001, 1'b0, 2};
        tbl[1] = '{1'b1, 12'd10, 32'hDEAD_BEEF, 0, 32'h0,         1'b0, 1};
        tbl[2] = '{1'b0, 12'd10, 32'h0,         0, 32'hDEAD_BEEF, 1'b0, 2};
        tbl[3] = '{1'b0, 12'd9,  32'h0,         5, 32'h5555_AAAA, 1'b0, 2};
        tbl[4] = '{1'b1, 12'd5,  32'h1234_5678, 2, 32'h0,         1'b0, 1};
        tbl[5] = '{1'b0, 12'd5,  32'h0,         0, 32'h1234_5678, 1'b0, 2};
        tbl[6] = '{1'b0, 12'd31, 32'h0,         0, 32'hA000_001F, 1'b0, 2};
`ifdef MEM_BUS_MASTER_RANGE_CHECK_EN
        tbl[7] = '{1'b0, 12'h020, 32'h0,        0, 32'h0,         1'b1, 1};
        tbl[8] = '{1'b1, 12'hFFF, 32'h0BAD_0BAD, 0, 32'h0,        1'b1, 1};
`else
        tbl[7] = '{1'b0, 12'h020, 32'h0,        0, 32'h0,         1'b0, 2};
        tbl[8] = '{1'b1, 12'hFFF, 32'h0BAD_0BAD, 0, 32'h0,        1'b0, 1};
`endif
        repeat (3) @(posedge clock);
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_m_rw_", {31'b0, m_rw_}, 32'd1);
        chk("rst_m_addr", {20'b0, m_addr}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_we", {31'b0, rsp_we}, 32'd0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        for (int i = 0; i < 9; i++) run(tbl[i]);
`ifdef MEM_BUS_MASTER_RANGE_CHECK_EN
        chk("err_count", {16'b0, dut.err_count}, 32'd2);
`endif
        // Reset while the read of addr 3 is in its capture cycle.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 12'd3;
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(posedge clock); #1;
        chk("pre_reset_busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("mid_rst_m_rw_", {31'b0, m_rw_}, 32'd1);
        chk("mid_rst_m_addr", {20'b0, m_addr}, 32'd0);
        chk("mid_rst_rsp_rdata", rsp_rdata, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("post_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        run('{1'b0, 12'd3, 32'h0, 0, 32'h4800_1001, 1'b0, 2});
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
CPU-side initiator for the single-port synchronous memory bus (m_addr / m_data / m_rw_).
- Accepts one word read or write request at a time from the core (fetch/load/store arbiter) over a valid/ready handshake.
- Sequences the bus cycle, owns the tri-state m_data driver, and returns read data or a write acknowledge over a valid/ready response channel.
- Single outstanding transaction; sits between the core and the memory model.

Parameters:
ADDR_W, 12, width of req_addr and m_addr
DATA_W, 32, width of data paths and m_data
MEM_DEPTH, 32, number of implemented words; addresses >= MEM_DEPTH are out of range

Ports:
clock  input  1  system clock
reset  input  1  reset
req_valid  input  1  request present
req_ready  output  1  master can accept request
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  word address
req_wdata  input  DATA_W  write data
rsp_valid  output  1  response present
rsp_ready  input  1  core accepts response
rsp_we  output  1  echo of req_we for this response
rsp_rdata  output  DATA_W  read data (0 for writes)
rsp_err  output  1  out-of-range request (optional feature)
m_addr  output  ADDR_W  bus address
m_data  inout  DATA_W  bus data, driven by master only in WR
m_rw_  output  1  1 = read, 0 = write
busy  output  1  FSM not in IDLE

Behaviour:
- Clocking and reset: reset, asynchronous, active-high; clock, clock. All state on posedge clock.
- Reset values: state IDLE; req_ready 1; rsp_valid 0; rsp_we 0; rsp_rdata 0; rsp_err 0; m_addr 0; m_rw_ 1; m_data high-Z; busy 0.
- Request accept: happens when req_valid && req_ready at edge E0. The request is latched into addr, we and wdata registers.
- req_ready: 1 only in IDLE, and only when rsp_valid == 0.
- States: IDLE, RD, RD_CAP, WR, RSP.
  - IDLE: on accept, go to WR if req_we, else RD.
  - RD: m_addr = latched addr, m_rw_ = 1, m_data released. The memory registers data at edge E1. Next state RD_CAP.
  - RD_CAP: m_rw_ = 1, m_addr held. At E2, sample m_data into rsp_rdata, set rsp_valid = 1 and rsp_we = 0. Next state RSP.
  - WR: m_addr = addr, m_data driven with wdata, m_rw_ = 0. The memory writes at E1. At E1, set rsp_valid = 1, rsp_we = 1, rsp_rdata = 0. Next state RSP.
  - RSP: hold all rsp_* stable while rsp_ready == 0. On rsp_valid && rsp_ready, clear rsp_valid and return to IDLE.
- Latency: read rsp_valid 2 cycles after accept; write rsp_valid 1 cycle after accept.
- m_data output enable: asserted only while in WR. Released on the same edge the FSM leaves WR, giving a turnaround cycle before any following RD.
- m_rw_: returns to 1 in every state except WR, so idle bus cycles are harmless reads.
- m_addr: holds its last value when idle (no glitching to 0).
- Back-to-back: a new request is accepted no earlier than the edge after the response handshake. Maximum throughput is one read per 4 cycles and one write per 3 cycles with rsp_ready tied high.
- Simultaneous events: req_valid is ignored while not ready; no queuing.
- Reset mid-operation: immediate return to reset values. Any pending response is discarded, and m_data is released asynchronously.

Optional Feature:
Macro MEM_BUS_MASTER_RANGE_CHECK_EN.
- Defined:
  - On accept with req_addr >= MEM_DEPTH, no bus cycle is issued: m_rw_ stays 1 and m_addr is not updated.
  - FSM goes IDLE -> RSP with rsp_valid = 1 and rsp_err = 1 one cycle after accept; rsp_rdata = 0 and rsp_we echoes req_we.
  - A 16-bit saturating err_count register increments per error and resets to 0.
- Undefined: addresses pass unchecked, rsp_err is tied 0, and no counter is generated.

Decomposition:
- Package mem_bus_pkg: state enum (IDLE, RD, RD_CAP, WR, RSP); ADDR_W, DATA_W and MEM_DEPTH defaults; the M_READ = 1 / M_WRITE = 0 constants for m_rw_.
- No sub-module required. The tri-state driver is a single continuous assignment in the top module.

Test Plan:
- Memory after reset; read addr 0 with rsp_ready = 1 → rsp_valid exactly 2 cycles after accept, rsp_rdata = 32'h28000001, rsp_we = 0; m_rw_ stays 1 throughout.
- Write addr 10 data 32'hDEADBEEF, then read addr 10 → write ack 1 cycle after accept with m_rw_ = 0 for exactly one cycle; read returns 32'hDEADBEEF; m_data is high-Z during the RD cycle.
- Read addr 9 with rsp_ready held 0 for 5 cycles → rsp_valid and rsp_rdata = 32'h5555AAAA stable throughout; req_ready = 0 throughout; exactly one handshake.
- With MEM_BUS_MASTER_RANGE_CHECK_EN, read addr 12'h020 → rsp_err = 1 one cycle after accept, no m_rw_ or m_addr activity, err_count = 1. Without the macro, the same request performs a normal bus read with rsp_err = 0.
- Assert reset during RD_CAP of a read of addr 3 → all outputs take reset values asynchronously with no rsp_valid. After deassertion, a read of addr 3 returns 32'h48001001.
